// File: rtl/ctrl_hazard_sched_pkg.sv
// Shared encodings for the pipeline hazard scheduler: FSM states, hold source codes
// and the fixed-priority hold arbiter.
package ctrl_hazard_sched_pkg;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        CTRL_IDLE      = 2'd0,
        CTRL_HOLD      = 2'd1,
        CTRL_FLUSH     = 2'd2,
        CTRL_TRAP_WAIT = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        HOLD_SRC_NONE = 2'd0,
        HOLD_SRC_LDU  = 2'd1,
        HOLD_SRC_DIV  = 2'd2,
        HOLD_SRC_BUS  = 2'd3
    } hold_src_e;

    // Bus beats divider beats load-use.
    function automatic hold_src_e hold_winner(input logic bus, input logic div, input logic ldu);
        if (bus) begin
            return HOLD_SRC_BUS;
        end else if (div) begin
            return HOLD_SRC_DIV;
        end else if (ldu) begin
            return HOLD_SRC_LDU;
        end
        return HOLD_SRC_NONE;
    endfunction

endpackage

// File: rtl/ctrl_flush_timer.sv
// Loadable down-counter with terminal-count flag; used for the flush window
// and, at a wider width, for the hold watchdog.
module ctrl_flush_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // Stops at zero rather than wrapping so done stays asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/ctrl_hazard_sched.sv
// Registered hazard scheduler: arbitrates trap/jump redirects against bus/div/load-use
// stalls and drives flush, hold and the PC redirect with one cycle of latency.
//
//  state          | meaning
//  CTRL_IDLE      | no hazard; redirects issue immediately
//  CTRL_HOLD      | pipeline frozen by a stall source; jumps parked in pending slot
//  CTRL_FLUSH     | flush window running; wrong-path jumps ignored
//  CTRL_TRAP_WAIT | trap accepted but waiting for bus/div to finish
module ctrl_hazard_sched
    import ctrl_hazard_sched_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int HOLD_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_jump_flag_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              int_req_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    output logic              int_ack_o,
    input  logic              bus_hold_i,
    input  logic              div_hold_i,
    input  logic              ldu_hold_i,
    output logic              pipeline_flush_flag_o,
    output logic              pc_jump_valid_o,
    output logic [ADDR_W-1:0] pc_jump_o,
    output logic              pipeline_hold_flag_o,
    output logic [1:0]        hold_src_o,
    output logic              hold_timeout_o
);

    localparam int WD_W = $clog2(HOLD_TIMEOUT + 1);

    ctrl_state_e       state;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              int_pend;

    logic              any_hold;
    hold_src_e         hold_win;
    logic              redir_go;
    logic              redir_trap;
    logic [ADDR_W-1:0] redir_addr;
    logic              flush_done;
    logic              wd_done;
    logic              int_new;

    assign any_hold = bus_hold_i | div_hold_i | ldu_hold_i;
    assign hold_win = hold_winner(bus_hold_i, div_hold_i, ldu_hold_i);

    // An acked trap request is still visible for one cycle; don't latch it again.
    assign int_new = int_req_i & ~int_ack_o;

    always_comb begin
        redir_go   = 1'b0;
        redir_trap = 1'b0;
        redir_addr = pend_addr;
        if (!any_hold) begin
            case (state)
                CTRL_IDLE, CTRL_HOLD: begin
                    if (int_req_i) begin
                        redir_go   = 1'b1;
                        redir_trap = 1'b1;
                        redir_addr = int_addr_i;
                    end else if (ex_jump_flag_i) begin
                        redir_go   = 1'b1;
                        redir_addr = ex_jump_addr_i;
                    end else if (pend_valid) begin
                        redir_go   = 1'b1;
                    end
                end
                CTRL_TRAP_WAIT: begin
                    redir_go   = 1'b1;
                    redir_trap = 1'b1;
                    redir_addr = int_addr_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= CTRL_IDLE;
            pend_valid            <= 1'b0;
            pend_addr             <= '0;
            int_pend              <= 1'b0;
            int_ack_o             <= 1'b0;
            pipeline_flush_flag_o <= 1'b0;
            pc_jump_valid_o       <= 1'b0;
            pc_jump_o             <= '0;
            pipeline_hold_flag_o  <= 1'b0;
            hold_src_o            <= HOLD_SRC_NONE;
            hold_timeout_o        <= 1'b0;
        end else begin
            int_ack_o             <= 1'b0;
            pc_jump_valid_o       <= 1'b0;
            pipeline_flush_flag_o <= 1'b0;
            pipeline_hold_flag_o  <= any_hold;
            hold_src_o            <= hold_win;
            if (pipeline_hold_flag_o && wd_done) begin
                hold_timeout_o <= 1'b1;
            end

            if (redir_go) begin
                state                 <= CTRL_FLUSH;
                pipeline_flush_flag_o <= 1'b1;
                pc_jump_valid_o       <= 1'b1;
                pc_jump_o             <= redir_addr;
                int_ack_o             <= redir_trap;
                pend_valid            <= 1'b0;
                int_pend              <= 1'b0;
            end else begin
                case (state)
                    CTRL_IDLE, CTRL_HOLD: begin
                        if (int_req_i) begin
                            state <= CTRL_TRAP_WAIT;
                        end else if (any_hold) begin
                            state <= CTRL_HOLD;
                            if (ex_jump_flag_i) begin
                                pend_valid <= 1'b1;
                                pend_addr  <= ex_jump_addr_i;
                            end
                        end else begin
                            state <= CTRL_IDLE;
                        end
                    end
                    CTRL_TRAP_WAIT: begin
                        state <= CTRL_TRAP_WAIT;
                    end
                    CTRL_FLUSH: begin
                        if (int_new) begin
                            int_pend <= 1'b1;
                        end
                        if (!flush_done) begin
                            pipeline_flush_flag_o <= 1'b1;
                            pipeline_hold_flag_o  <= 1'b0;
                            hold_src_o            <= HOLD_SRC_NONE;
                        end else if (int_pend || int_new) begin
                            state <= CTRL_TRAP_WAIT;
                        end else if (any_hold) begin
                            state <= CTRL_HOLD;
                        end else begin
                            state <= CTRL_IDLE;
                        end
                    end
                    default: state <= CTRL_IDLE;
                endcase
            end
        end
    end

    // Preloaded outside FLUSH so the window starts counting on entry.
    ctrl_flush_timer #(.W(FLUSH_CNT_W)) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state != CTRL_FLUSH),
        .load_val (FLUSH_CNT_W'(FLUSH_CYCLES - 1)),
        .en       (state == CTRL_FLUSH),
        .done     (flush_done)
    );

    // Reaches zero once the hold output has been high HOLD_TIMEOUT cycles in a row.
    ctrl_flush_timer #(.W(WD_W)) u_hold_wdog (
        .clk      (clk),
        .rst      (rst),
        .load     (!pipeline_hold_flag_o),
        .load_val (WD_W'(HOLD_TIMEOUT - 1)),
        .en       (pipeline_hold_flag_o),
        .done     (wd_done)
    );

endmodule

// File: tb/tb_ctrl_hazard_sched.sv
// Directed bench for ctrl_hazard_sched: a cycle-by-cycle vector table plus
// hand-written trap-wait and watchdog sequences.
module tb_ctrl_hazard_sched;

    localparam int HT = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_flag_i;
    logic [31:0] ex_jump_addr_i;
    logic        int_req_i;
    logic [31:0] int_addr_i;
    logic        int_ack_o;
    logic        bus_hold_i, div_hold_i, ldu_hold_i;
    logic        pipeline_flush_flag_o;
    logic        pc_jump_valid_o;
    logic [31:0] pc_jump_o;
    logic        pipeline_hold_flag_o;
    logic [1:0]  hold_src_o;
    logic        hold_timeout_o;

    always #5 clk = ~clk;

    ctrl_hazard_sched #(.ADDR_W(32), .FLUSH_CYCLES(2), .HOLD_TIMEOUT(HT)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ex_jump_flag_i        (ex_jump_flag_i),
        .ex_jump_addr_i        (ex_jump_addr_i),
        .int_req_i             (int_req_i),
        .int_addr_i            (int_addr_i),
        .int_ack_o             (int_ack_o),
        .bus_hold_i            (bus_hold_i),
        .div_hold_i            (div_hold_i),
        .ldu_hold_i            (ldu_hold_i),
        .pipeline_flush_flag_o (pipeline_flush_flag_o),
        .pc_jump_valid_o       (pc_jump_valid_o),
        .pc_jump_o             (pc_jump_o),
        .pipeline_hold_flag_o  (pipeline_hold_flag_o),
        .hold_src_o            (hold_src_o),
        .hold_timeout_o        (hold_timeout_o)
    );

    typedef struct {
        logic        r;
        logic        j;
        logic [31:0] ja;
        logic        i;
        logic [31:0] ia;
        logic        b, d, l;
        logic        e_fl, e_v;
        logic [31:0] e_pc;
        logic        e_h;
        logic [1:0]  e_src;
        logic        e_ack;
    } vec_t;

    vec_t vecs[$];
    int tests_run    = 0;
    int tests_failed = 0;

    function automatic vec_t mk(input logic r, input logic j, input logic [31:0] ja,
                                input logic i, input logic [31:0] ia,
                                input logic b, input logic d, input logic l,
                                input logic fl, input logic v, input logic [31:0] pc,
                                input logic h, input logic [1:0] src, input logic ack);
        vec_t t;
        t.r = r; t.j = j; t.ja = ja; t.i = i; t.ia = ia;
        t.b = b; t.d = d; t.l = l;
        t.e_fl = fl; t.e_v = v; t.e_pc = pc; t.e_h = h; t.e_src = src; t.e_ack = ack;
        return t;
    endfunction

    task automatic drive(input logic r, input logic j, input logic [31:0] ja,
                         input logic i, input logic [31:0] ia,
                         input logic b, input logic d, input logic l);
        rst = r; ex_jump_flag_i = j; ex_jump_addr_i = ja;
        int_req_i = i; int_addr_i = ia;
        bus_hold_i = b; div_hold_i = d; ldu_hold_i = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {flush, valid, pc, hold, src, ack, timeout}
    function automatic logic [63:0] outs();
        return {25'd0, pipeline_flush_flag_o, pc_jump_valid_o, pc_jump_o,
                pipeline_hold_flag_o, hold_src_o, int_ack_o, hold_timeout_o};
    endfunction

    initial begin
        int waited;
        int valids;
        int first_n;
        vec_t t;

        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //                 r j ja       i ia      b d l   fl v pc       h src ack
        vecs.push_back(mk(1,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h0,   0,0,0)); // reset
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,32'h100, 0,32'h0,  0,0,0,  1,1,32'h100, 0,0,0)); // jump in IDLE
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  1,0,32'h100, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h100, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h100, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,1,0,  0,0,32'h100, 1,2,0)); // div hold x5
        vecs.push_back(mk(0,1,32'h200, 0,32'h0,  0,1,0,  0,0,32'h100, 1,2,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,1,0,  0,0,32'h100, 1,2,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,1,0,  0,0,32'h100, 1,2,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,1,0,  0,0,32'h100, 1,2,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  1,1,32'h200, 0,0,0)); // pending issued
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  1,0,32'h200, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h200, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  1,1,1,  0,0,32'h200, 1,3,0)); // priority
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,1,1,  0,0,32'h200, 1,2,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,1,  0,0,32'h200, 1,1,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h200, 0,0,0));
        vecs.push_back(mk(0,1,32'h300, 1,32'h8,  0,0,0,  1,1,32'h8,   0,0,1)); // trap beats jump
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  1,0,32'h8,   0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h8,   0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h8,   0,0,0));
        vecs.push_back(mk(0,1,32'h400, 0,32'h0,  0,0,0,  1,1,32'h400, 0,0,0)); // wrong-path jumps
        vecs.push_back(mk(0,1,32'h500, 0,32'h0,  0,0,0,  1,0,32'h400, 0,0,0));
        vecs.push_back(mk(0,1,32'h600, 0,32'h0,  0,0,0,  0,0,32'h400, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h400, 0,0,0));
        vecs.push_back(mk(0,1,32'h700, 0,32'h0,  0,0,0,  1,1,32'h700, 0,0,0)); // rst mid-flush
        vecs.push_back(mk(1,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,32'h900, 0,32'h0,  0,1,0,  0,0,32'h0,   1,2,0)); // park, then rst
        vecs.push_back(mk(1,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,32'hA00, 0,32'h0,  0,0,0,  1,1,32'hA00, 0,0,0)); // irq during flush
        vecs.push_back(mk(0,0,32'h0,   1,32'h40, 0,0,0,  1,0,32'hA00, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   1,32'h40, 0,0,0,  0,0,32'hA00, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   1,32'h40, 0,0,0,  1,1,32'h40,  0,0,1));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  1,0,32'h40,  0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'h40,  0,0,0));
        vecs.push_back(mk(0,1,32'hB00, 0,32'h0,  0,0,0,  1,1,32'hB00, 0,0,0)); // hold masked in flush
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  1,0,0,  1,0,32'hB00, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  1,0,0,  0,0,32'hB00, 1,3,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'hB00, 0,0,0));
        vecs.push_back(mk(0,1,32'hC00, 0,32'h0,  0,0,1,  0,0,32'hB00, 1,1,0)); // pending overwrite
        vecs.push_back(mk(0,1,32'hD00, 0,32'h0,  0,0,1,  0,0,32'hB00, 1,1,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  1,1,32'hD00, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  1,0,32'hD00, 0,0,0));
        vecs.push_back(mk(0,0,32'h0,   0,32'h0,  0,0,0,  0,0,32'hD00, 0,0,0));

        for (int k = 0; k < vecs.size(); k++) begin
            t = vecs[k];
            drive(t.r, t.j, t.ja, t.i, t.ia, t.b, t.d, t.l);
            tick();
            check($sformatf("vec%0d", k), outs(),
                  {25'd0, t.e_fl, t.e_v, t.e_pc, t.e_h, t.e_src, t.e_ack, 1'b0});
        end

        // Trap during bus hold: wait for the bus, then vector; parked jump discarded.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        check("tw_hold", {62'd0, pipeline_hold_flag_o, pipeline_flush_flag_o}, 64'd2);
        drive(0, 1, 32'hE00, 0, 0, 1, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 32'h80, 1, 0, 0);
            tick();
            check($sformatf("tw_wait%0d", k),
                  {61'd0, pipeline_flush_flag_o, int_ack_o, pipeline_hold_flag_o}, 64'd1);
        end
        drive(0, 0, 0, 1, 32'h80, 0, 0, 0);
        waited = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (int_ack_o) begin
                waited = k;
                break;
            end
        end
        check("tw_ack_latency", 64'(waited), 64'd1);
        check("tw_redirect",
              {30'd0, pipeline_flush_flag_o, pc_jump_valid_o, pc_jump_o}, {30'd0, 2'b11, 32'h80});
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        valids = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pc_jump_valid_o) valids++;
        end
        check("tw_no_pending", 64'(valids), 64'd0);
        check("tw_pc_kept", 64'(pc_jump_o), 64'h80);

        // Watchdog: long bus hold.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        first_n = 0;
        for (int n = 1; n <= 1100; n++) begin
            tick();
            if (hold_timeout_o && first_n == 0) first_n = n;
        end
        check("wd_first_set", 64'(first_n), 64'(HT + 1));
        check("wd_hold_kept", {62'd0, hold_timeout_o, pipeline_hold_flag_o}, 64'd3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick();
        check("wd_sticky", {62'd0, hold_timeout_o, pipeline_hold_flag_o}, 64'd2);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("wd_reset", outs(), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
